btn_debounce: RTL
=================

Name: btn_debounce

Overview:
- Per-channel debouncer and synchronizer for raw mechanical push-button pins.
- Sits directly upstream of the SoC button PIO. Its btn_out drives the PIO in_port. The PIO's falling-edge capture then sees exactly one clean edge per physical press.
- Also provides one-cycle press, release and long-press strobes for local fabric logic.

Parameters:
- NUM_BTN, 1, number of independent button channels.
- DEBOUNCE_CYCLES, 1000000, stable-level cycles required before a change is accepted (20 ms at 50 MHz); legal range >= 2.
- LONG_PRESS_CYCLES, 50000000, cycles a confirmed press must be held before long_press fires (1 s at 50 MHz); legal range >= 2.
- IDLE_LEVEL, 1, pin level when the button is released (1 = active-low buttons with pull-ups).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- btn_in  in  NUM_BTN  raw asynchronous button pins.
- btn_out  out  NUM_BTN  debounced level, same polarity as btn_in.
- press_pulse  out  NUM_BTN  one-cycle strobe when a press is confirmed.
- release_pulse  out  NUM_BTN  one-cycle strobe when a release is confirmed.
- long_press  out  NUM_BTN  one-cycle strobe when a press reaches LONG_PRESS_CYCLES.

Behaviour:
- Reset and clock: reset reset_n, asynchronous, active-low; clock clk.
- Reset values:
  - sync stages and btn_out = {NUM_BTN{IDLE_LEVEL}};
  - all pulses = 0;
  - all counters = 0;
  - every FSM in RELEASED.
- btn_out resets to the idle level, so the downstream PIO sees no spurious edge on reset exit.
- Synchronizer: two flops per channel (s1, s2). Only s2 is used downstream.
- Channel FSM states:
  - RELEASED: btn_out = IDLE_LEVEL.
  - PRESS_WAIT: btn_out = IDLE_LEVEL.
  - PRESSED: btn_out = ~IDLE_LEVEL.
  - RELEASE_WAIT: btn_out = ~IDLE_LEVEL.
- RELEASED -> PRESS_WAIT when s2 != IDLE_LEVEL. The debounce counter starts at 1.
- PRESS_WAIT:
  - If s2 == IDLE_LEVEL: return to RELEASED, counter cleared (bounce rejected).
  - Else counter increments.
  - When counter == DEBOUNCE_CYCLES-1 and s2 is still pressed: on the next edge go to PRESSED, flip btn_out, assert press_pulse for 1 cycle, clear the debounce counter, clear the hold counter.
- PRESSED -> RELEASE_WAIT when s2 == IDLE_LEVEL.
- RELEASE_WAIT:
  - Symmetric to PRESS_WAIT.
  - Bounce back to pressed returns to PRESSED with the counter cleared.
  - Completion goes to RELEASED, flips btn_out and asserts release_pulse.
- Latency: counting the first edge that samples the new stable btn_in level as edge 1, btn_out and the strobe update on edge DEBOUNCE_CYCLES+2.
- Debounce counter width = clog2(DEBOUNCE_CYCLES). It never exceeds DEBOUNCE_CYCLES-1; no wrap.
- Hold counter:
  - Increments every cycle while btn_out is pressed (PRESSED and RELEASE_WAIT).
  - Width = clog2(LONG_PRESS_CYCLES+1).
  - Saturates at LONG_PRESS_CYCLES.
- long_press: asserted for exactly 1 cycle on the edge where the hold counter reaches LONG_PRESS_CYCLES-1 -> LONG_PRESS_CYCLES. That is LONG_PRESS_CYCLES edges after the press_pulse edge.
  - No auto-repeat.
  - Cleared with the hold counter on the next confirmed press.
  - If release is confirmed first, long_press never fires for that press.
- Simultaneous events:
  - press_pulse and release_pulse are never both high on one channel.
  - long_press may coincide with the start of RELEASE_WAIT; it still fires because btn_out is still pressed.
- Channel independence: channels are fully independent. No shared counters.
- Reset mid-operation: any state or counter returns to its reset value immediately. No pulse is emitted during or on exit from reset.

Test Plan (NUM_BTN=2, DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32, IDLE_LEVEL=1):
- Reset, btn_in=2'b11 held -> btn_out=2'b11 and all pulses 0 throughout and after reset release.
- Clean press: btn_in[0] 1->0 held -> btn_out[0]=0 and press_pulse[0]=1 for 1 cycle on edge 10. btn_out[1] unchanged.
- Bounce: btn_in[0] toggles 0/1 every 3 cycles for 40 cycles, then held 0 -> no btn_out change during toggling. Exactly one press_pulse, 10 edges after the final transition.
- Long press: hold btn_in[0]=0 -> long_press[0] single pulse 32 edges after press_pulse. No further pulses over 200 cycles. Release -> release_pulse[0] once, 10 edges after btn_in returns to 1.
- Short press: press confirmed, release after 12 cycles -> release_pulse fires; long_press never asserts.
- Both channels pressed on the same cycle -> both press_pulses on the same edge. reset_n asserted mid-PRESS_WAIT -> btn_out=2'b11, no pulse, counters restart after reset release.

Source files
------------

// File: rtl/btn_debounce.sv
// Per-channel push-button synchronizer and debouncer.
// Each channel runs a two-flop synchronizer followed by a four-state FSM that only
// accepts a level change after it has been stable for DEBOUNCE_CYCLES cycles. The
// debounced level feeds a downstream PIO; one-cycle press, release and long-press
// strobes are provided for local logic.
module btn_debounce #(
   parameter int unsigned NUM_BTN           = 1,
   parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
   parameter int unsigned LONG_PRESS_CYCLES = 50000000,
   parameter bit          IDLE_LEVEL        = 1'b1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_BTN-1:0] btn_in,
   output logic [NUM_BTN-1:0] btn_out,
   output logic [NUM_BTN-1:0] press_pulse,
   output logic [NUM_BTN-1:0] release_pulse,
   output logic [NUM_BTN-1:0] long_press
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES + 1);

   localparam logic [DW-1:0] DEB_ONE   = DW'(1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

   localparam logic [NUM_BTN-1:0] IDLE_VEC = {NUM_BTN{IDLE_LEVEL}};

   localparam logic [1:0] ST_RELEASED     = 2'd0;
   localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
   localparam logic [1:0] ST_PRESSED      = 2'd2;
   localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

   logic [NUM_BTN-1:0] s1_q;
   logic [NUM_BTN-1:0] s2_q;

   // Two-flop synchronizer; resets to the idle level so no edge is seen on reset exit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q <= IDLE_VEC;
         s2_q <= IDLE_VEC;
      end else begin
         s1_q <= btn_in;
         s2_q <= s1_q;
      end
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      logic [1:0]    state_q, state_d;
      logic [DW-1:0] cnt_q, cnt_d;
      logic [HW-1:0] hold_q, hold_d;
      logic          press_q, press_d;
      logic          release_q, release_d;
      logic          long_q, long_d;
      logic          pin_pressed;
      logic          out_pressed;

      assign pin_pressed = (s2_q[i] != IDLE_LEVEL);
      assign out_pressed = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);

      // Debounce FSM, hold counter and strobe next-state logic.
      always_comb begin
         state_d   = state_q;
         cnt_d     = cnt_q;
         hold_d    = hold_q;
         press_d   = 1'b0;
         release_d = 1'b0;
         long_d    = 1'b0;

         case (state_q)
            ST_RELEASED: begin
               if (pin_pressed) begin
                  state_d = ST_PRESS_WAIT;
                  cnt_d   = DEB_ONE;
               end
            end
            ST_PRESS_WAIT: begin
               if (!pin_pressed) begin
                  state_d = ST_RELEASED;
                  cnt_d   = '0;
               end else if (cnt_q == DEB_LAST) begin
                  state_d = ST_PRESSED;
                  cnt_d   = '0;
                  press_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_PRESSED: begin
               if (!pin_pressed) begin
                  state_d = ST_RELEASE_WAIT;
                  cnt_d   = DEB_ONE;
               end
            end
            ST_RELEASE_WAIT: begin
               if (pin_pressed) begin
                  state_d = ST_PRESSED;
                  cnt_d   = '0;
               end else if (cnt_q == DEB_LAST) begin
                  state_d   = ST_RELEASED;
                  cnt_d     = '0;
                  release_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_RELEASED;
               cnt_d   = '0;
            end
         endcase

         // Hold time only advances while the debounced level reads pressed; saturation
         // guarantees long_press fires at most once per press.
         if (out_pressed) begin
            if (hold_q != HOLD_MAX) begin
               hold_d = hold_q + 1'b1;
            end
            if (hold_q == HOLD_LAST) begin
               long_d = 1'b1;
            end
         end

         // A newly confirmed press starts a fresh hold measurement.
         if (press_d) begin
            hold_d = '0;
         end
      end

      // Channel state, counters and registered strobes.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            state_q   <= ST_RELEASED;
            cnt_q     <= '0;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
         end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
         end
      end

      assign btn_out[i]       = out_pressed ? ~IDLE_LEVEL : IDLE_LEVEL;
      assign press_pulse[i]   = press_q;
      assign release_pulse[i] = release_q;
      assign long_press[i]    = long_q;
   end

endmodule
